// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider with its sequencing
// FSM for RV32M DIV/DIVU/REM/REMU in the execute stage. It raises div_stall
// while the divide occupies E and pulses result_valid for one cycle when the
// result is ready.
// Optional build macro: DIV_FAST_PATH_EN. When defined, a divisor magnitude
// larger than the dividend magnitude finishes in one cycle, like the other
// special cases. When undefined, those operands take the full iterative path.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            div_stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE_VAL = XLEN'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Two's-complement negation of a full-width value.
  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return ~v + ONE_VAL;
  endfunction

  // Restores the sign of an unsigned magnitude result.
  function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] mag,
                                               input logic            neg);
    return neg ? twos_neg(mag) : mag;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             rem_sel_q, rem_sel_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             stall_c;
  logic             valid_c;

  // Operand decode for the instruction currently presented in E.
  logic            in_signed;
  logic            dd_neg;
  logic            dv_neg;
  logic [XLEN-1:0] dd_mag;
  logic [XLEN-1:0] dv_mag;
  logic            div_zero;
  logic            sgn_ovf;
  logic            fast_lt;

  assign in_signed = ~op[0];
  assign dd_neg    = in_signed & dividend[XLEN-1];
  assign dv_neg    = in_signed & divisor[XLEN-1];
  assign dd_mag    = dd_neg ? twos_neg(dividend) : dividend;
  assign dv_mag    = dv_neg ? twos_neg(divisor) : divisor;
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = in_signed & (dividend == MIN_VAL) & (divisor == '1);
`ifdef DIV_FAST_PATH_EN
  assign fast_lt   = (dv_mag > dd_mag);
`else
  assign fast_lt   = 1'b0;
`endif

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic            trial_ok;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;

  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign trial_ok = ~trial[XLEN];
  assign rem_nx   = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx   = {quo_q[XLEN-2:0], trial_ok};

  // Next-state, datapath update and output decode for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    stall_c   = 1'b0;
    valid_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_c = start & ~flush;
        if (start && !flush) begin
          rem_sel_d = op[1];
          neg_quo_d = dd_neg ^ dv_neg;
          neg_rem_d = dd_neg;
          if (div_zero) begin
            result_d = op[1] ? dividend : '1;
            state_d  = S_DONE;
          end else if (sgn_ovf) begin
            result_d = op[1] ? '0 : MIN_VAL;
            state_d  = S_DONE;
          end else if (fast_lt) begin
            result_d = op[1] ? dividend : '0;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = dd_mag;
            dvs_d   = dv_mag;
            cnt_d   = CNT_W'(XLEN);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        rem_d   = rem_nx;
        quo_d   = quo_nx;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = rem_sel_q ? sign_fix(rem_nx, neg_rem_q)
                               : sign_fix(quo_nx, neg_quo_q);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // start still belongs to the retiring instruction here; ignore it.
        valid_c = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flushed instruction never completes and never updates result.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      valid_c  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign div_stall    = stall_c & ~rst;
  assign result_valid = valid_c;
  assign result       = result_q;

endmodule
